// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the inst/data SRAM port arbiter: FSM states, owner ids
// and the width of the bundled request bus that the grant mux selects.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_e;

    // {wr, size, wstrb, addr, wdata, req}
    function automatic int arb_req_bus_wd(input int addr_w, input int data_w);
        return 1 + 2 + (data_w / 8) + addr_w + data_w + 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// SRAM-like handshake bundle around the arbiter: inst and data requester
// ports plus the single bridge port. slave = arbiter view, master = environment.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic                  inst_wr;
    logic [1:0]            inst_size;
    logic [DATA_W/8-1:0]   inst_wstrb;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_wdata;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between inst and data requests.
// Optional SRAM_ARB_RR_EN: round-robin on contention using rr_last; default is data-over-inst.
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
(
    input  logic       inst_req,
    input  logic       data_req,
`ifdef SRAM_ARB_RR_EN
    input  arb_owner_e rr_last,
`endif
    output logic       win_vld,
    output arb_owner_e win
);

    always_comb begin
        win_vld = inst_req | data_req;
        win     = ARB_OWN_INST;
`ifdef SRAM_ARB_RR_EN
        if (inst_req && data_req) begin
            win = (rr_last == ARB_OWN_DATA) ? ARB_OWN_INST : ARB_OWN_DATA;
        end else if (data_req) begin
            win = ARB_OWN_DATA;
        end
`else
        // Data wins so a stalled MEM stage can never be starved by fetch.
        if (data_req) begin
            win = ARB_OWN_DATA;
        end
`endif
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bridge port between fetch and load/store, one transaction in flight.
// Request reaches the bridge in the arbitration cycle; grant is locked until addr_ok. Macro: SRAM_ARB_RR_EN.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus
);

    localparam int BUS_WD = arb_req_bus_wd(ADDR_W, DATA_W);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e sel_owner;
    arb_owner_e win;
    logic       win_vld;
    logic       fwd;
    logic       addr_hs;
    logic       resp;

    logic [BUS_WD-1:0] inst_bus;
    logic [BUS_WD-1:0] data_bus;
    logic [BUS_WD-1:0] sel_bus;
    logic [BUS_WD-1:0] out_bus;

    assign inst_bus = {bus.inst_wr, bus.inst_size, bus.inst_wstrb,
                       bus.inst_addr, bus.inst_wdata, bus.inst_req};
    assign data_bus = {bus.data_wr, bus.data_size, bus.data_wstrb,
                       bus.data_addr, bus.data_wdata, bus.data_req};

`ifdef SRAM_ARB_RR_EN
    arb_owner_e rr_last_q, rr_last_d;

    sram_arb_pick u_pick (
        .inst_req (bus.inst_req),
        .data_req (bus.data_req),
        .rr_last  (rr_last_q),
        .win_vld  (win_vld),
        .win      (win)
    );
`else
    sram_arb_pick u_pick (
        .inst_req (bus.inst_req),
        .data_req (bus.data_req),
        .win_vld  (win_vld),
        .win      (win)
    );
`endif

    // Only IDLE looks at the live winner; afterwards the registered owner steers the mux.
    always_comb begin
        sel_owner = owner_q;
        fwd       = 1'b0;
        if (state_q == ARB_IDLE && win_vld) begin
            sel_owner = win;
            fwd       = 1'b1;
        end else if (state_q == ARB_ADDR) begin
            fwd       = 1'b1;
        end
    end

    assign sel_bus = (sel_owner == ARB_OWN_DATA) ? data_bus : inst_bus;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_hs = 1'b0;
        resp    = 1'b0;
`ifdef SRAM_ARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    owner_d = win;
                    if (bus.addr_ok) begin
                        addr_hs = 1'b1;
                        state_d = ARB_WAIT;
                    end else begin
                        state_d = ARB_ADDR;
                    end
                end
            end
            ARB_ADDR: begin
                // sel_bus[0] is the owner's req; a dropped req keeps the lock but never handshakes.
                if (bus.addr_ok && sel_bus[0]) begin
                    addr_hs = 1'b1;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus.data_ok) begin
                    resp    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
`ifdef SRAM_ARB_RR_EN
        if (addr_hs) begin
            rr_last_d = sel_owner;
        end
`endif
    end

    assign out_bus = (fwd && !reset) ? sel_bus : '0;
    assign {bus.wr, bus.size, bus.wstrb, bus.addr, bus.wdata, bus.req} = out_bus;

    assign bus.inst_addr_ok = !reset && addr_hs && (sel_owner == ARB_OWN_INST);
    assign bus.data_addr_ok = !reset && addr_hs && (sel_owner == ARB_OWN_DATA);
    assign bus.inst_data_ok = !reset && resp && (owner_q == ARB_OWN_INST);
    assign bus.data_data_ok = !reset && resp && (owner_q == ARB_OWN_DATA);
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.rdata : '0;
    assign bus.data_rdata   = bus.data_data_ok ? bus.rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= ARB_OWN_INST;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed stimulus for sram_port_arbiter; a negedge monitor checks bridge
// address handshakes and requester responses against queues filled by the stimulus.
module tb_sram_port_arbiter;

    typedef struct packed {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_req_t;

    logic clk;
    logic reset;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_req_t    exp_addr_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr();
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 2'd2; bus.inst_wstrb = 4'h0;
        bus.inst_addr = 0; bus.inst_wdata = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2; bus.data_wstrb = 4'h0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.addr_ok = 0; bus.data_ok = 0; bus.rdata = 0;
    endtask

    task automatic inst_rd(input logic [31:0] a);
        bus.inst_req = 1; bus.inst_wr = 0; bus.inst_size = 2'd2;
        bus.inst_wstrb = 4'h0; bus.inst_addr = a; bus.inst_wdata = 0;
    endtask

    task automatic push_addr(input logic d, input logic w, input logic [3:0] st,
                             input logic [31:0] a, input logic [31:0] wd);
        exp_req_t e;
        e = '{is_data: d, wr: w, size: 2'd2, wstrb: st, addr: a, wdata: wd};
        exp_addr_q.push_back(e);
    endtask

    // Scoreboard monitor
    exp_req_t    m_e;
    logic [31:0] m_r;
    always @(negedge clk) begin
        if (bus.req && bus.addr_ok) begin
            if (exp_addr_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL addr_hs: unexpected handshake addr=%h (t=%0t)", bus.addr, $time);
            end else begin
                m_e = exp_addr_q.pop_front();
                chk("addr_hs", {7'd0, bus.inst_addr_ok, bus.data_addr_ok, bus.wr, bus.size,
                                bus.wstrb, bus.addr, bus.wdata},
                               {7'd0, ~m_e.is_data, m_e.is_data, m_e.wr, m_e.size,
                                m_e.wstrb, m_e.addr, m_e.wdata});
            end
        end
        if (bus.inst_data_ok) begin
            if (inst_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL inst_resp: unexpected inst_data_ok rdata=%h (t=%0t)", bus.inst_rdata, $time);
            end else begin
                m_r = inst_q.pop_front();
                chk("inst_rdata", {48'd0, bus.inst_rdata}, {48'd0, m_r});
            end
        end else begin
            chk("inst_rdata_idle", {48'd0, bus.inst_rdata}, 80'd0);
        end
        if (bus.data_data_ok) begin
            if (data_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL data_resp: unexpected data_data_ok rdata=%h (t=%0t)", bus.data_rdata, $time);
            end else begin
                m_r = data_q.pop_front();
                chk("data_rdata", {48'd0, bus.data_rdata}, {48'd0, m_r});
            end
        end else begin
            chk("data_rdata_idle", {48'd0, bus.data_rdata}, 80'd0);
        end
    end

    initial begin
        // Reset: outputs stay 0 even with a request and addr_ok present
        reset = 1; clr();
        inst_rd(32'h1c00_0000); bus.addr_ok = 1;
        mid();
        chk("rst_req", {79'd0, bus.req}, 80'd0);
        chk("rst_addr", {48'd0, bus.addr}, 80'd0);
        chk("rst_inst_addr_ok", {79'd0, bus.inst_addr_ok}, 80'd0);
        step(); clr();
        step(); reset = 0;

        // Inst-only read
        inst_rd(32'h1c00_0000); bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_0000, 0); inst_q.push_back(32'h0280_0c0c);
        mid(); chk("t1_addr_ok_c0", {79'd0, bus.inst_addr_ok}, 80'd1);
        step(); clr();
        mid(); chk("t1_req_wait", {79'd0, bus.req}, 80'd0);
        step(); bus.data_ok = 1; bus.rdata = 32'h0280_0c0c;
        mid(); chk("t1_data_ok_c2", {78'd0, bus.inst_data_ok, bus.data_data_ok}, 80'b10);
        step(); clr();

        // Simultaneous: data store first, inst after data_data_ok
        inst_rd(32'h1c00_0004);
        bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'hf;
        bus.data_addr = 32'h0000_1000; bus.data_wdata = 32'hdead_beef; bus.addr_ok = 1;
        push_addr(1, 1, 4'hf, 32'h0000_1000, 32'hdead_beef); data_q.push_back(32'h0);
        mid(); chk("t2_data_first", {79'd0, bus.data_addr_ok}, 80'd1);
        step(); bus.data_req = 0; bus.data_wr = 0; bus.addr_ok = 0;
        mid(); chk("t2_wait_req", {79'd0, bus.req}, 80'd0);
        step(); bus.data_ok = 1; bus.rdata = 32'h0;
        mid(); chk("t2_no_inst_grant", {78'd0, bus.req, bus.inst_addr_ok}, 80'd0);
        step(); bus.data_ok = 0; bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_0004, 0); inst_q.push_back(32'h1122_3344);
        mid(); chk("t2_inst_grant", {79'd0, bus.inst_addr_ok}, 80'd1);
        step(); clr();
        step(); bus.data_ok = 1; bus.rdata = 32'h1122_3344;
        step(); clr();

        // Grant lock: addr stable while addr_ok is low
        inst_rd(32'h1c00_0008);
        step(); bus.data_req = 1; bus.data_addr = 32'h0000_0020;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t3_lock_addr", {47'd0, bus.req, bus.addr}, {47'd0, 1'b1, 32'h1c00_0008});
            chk("t3_lock_no_data", {79'd0, bus.data_addr_ok}, 80'd0);
            step();
        end
        bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_0008, 0); inst_q.push_back(32'ha5a5_a5a5);
        step(); bus.inst_req = 0; bus.addr_ok = 0;
        step(); bus.data_ok = 1; bus.rdata = 32'ha5a5_a5a5;
        step(); bus.data_ok = 0; bus.addr_ok = 1;
        push_addr(1, 0, 4'h0, 32'h0000_0020, 0); data_q.push_back(32'h5a5a_0001);
        mid(); chk("t3_data_after", {79'd0, bus.data_addr_ok}, 80'd1);
        step(); clr();
        step(); bus.data_ok = 1; bus.rdata = 32'h5a5a_0001;
        step(); clr();

        // Spurious data_ok in IDLE
        bus.data_ok = 1; bus.rdata = 32'hffff_ffff;
        mid(); chk("t4_spurious", {78'd0, bus.inst_data_ok, bus.data_data_ok}, 80'd0);
        step(); clr();
        inst_rd(32'h1c00_0040); bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_0040, 0); inst_q.push_back(32'h0000_0040);
        mid(); chk("t4_still_idle", {79'd0, bus.inst_addr_ok}, 80'd1);
        step(); clr();
        step(); bus.data_ok = 1; bus.rdata = 32'h0000_0040;
        step(); clr();

        // Reset in WAIT: response abandoned, fresh request served
        inst_rd(32'h1c00_000c); bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_000c, 0);
        step(); clr(); reset = 1;
        mid(); chk("t5_rst_outs", {76'd0, bus.req, bus.inst_addr_ok, bus.inst_data_ok, bus.data_data_ok}, 80'd0);
        step(); reset = 0; bus.data_ok = 1; bus.rdata = 32'h0000_0bad;
        mid(); chk("t5_no_fwd", {78'd0, bus.inst_data_ok, bus.data_data_ok}, 80'd0);
        step(); clr();
        inst_rd(32'h1c00_0010); bus.addr_ok = 1;
        push_addr(0, 0, 4'h0, 32'h1c00_0010, 0); inst_q.push_back(32'h0000_1010);
        mid(); chk("t5_fresh_grant", {79'd0, bus.inst_addr_ok}, 80'd1);
        step(); clr();
        step(); bus.data_ok = 1; bus.rdata = 32'h0000_1010;
        step(); clr();

        // Back-to-back loads with the bridge always ready
        bus.data_req = 1; bus.data_addr = 32'h10; bus.addr_ok = 1;
        push_addr(1, 0, 4'h0, 32'h10, 0); data_q.push_back(32'h0000_0010);
        step(); bus.data_addr = 32'h14;
        mid(); chk("t6_one_outstanding", {78'd0, bus.req, bus.data_addr_ok}, 80'd0);
        step(); bus.data_ok = 1; bus.rdata = 32'h0000_0010;
        mid(); chk("t6_no_addr_on_resp", {78'd0, bus.req, bus.data_addr_ok}, 80'd0);
        step(); bus.data_ok = 0;
        push_addr(1, 0, 4'h0, 32'h14, 0); data_q.push_back(32'h0000_0014);
        mid(); chk("t6_second_addr", {79'd0, bus.data_addr_ok}, 80'd1);
        step(); clr();
        step(); bus.data_ok = 1; bus.rdata = 32'h0000_0014;
        step(); clr();
        step();

        chk("addr_q_drained", {48'd0, 32'(exp_addr_q.size())}, 80'd0);
        chk("inst_q_drained", {48'd0, 32'(inst_q.size())}, 80'd0);
        chk("data_q_drained", {48'd0, 32'(data_q.size())}, 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
